// File: rtl/display_pager_if.sv
// Result hand-off between the arithmetic block and the display pager.
// The producer drives a value with a one-cycle valid pulse and watches busy.
interface display_pager_if #(
  parameter int RESULT_W = 32
) ();
  logic [RESULT_W-1:0] result_in;
  logic                result_valid;
  logic                busy;

  modport master (output result_in, output result_valid, input busy);
  modport slave  (input result_in, input result_valid, output busy);
endinterface

// File: rtl/display_pager.sv
// Paged 7-segment controller: double-dabble binary->BCD conversion, leading-zero
// blanking, minus sign, wrap-around paging and a multiplexed anode scan.
module display_pager #(
  parameter  int RESULT_W        = 32,
  parameter  int SIGNED          = 1,
  parameter  int DIGITS_PER_PAGE = 4,
  parameter  int NUM_PAGES       = 3,
  parameter  int REFRESH_CYCLES  = 100000,
  localparam int PAGE_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         select,
  input  logic                         advance,
  input  logic [4*DIGITS_PER_PAGE-1:0] data_in,
  display_pager_if.slave               res,
  output logic [DIGITS_PER_PAGE-1:0]   an_out,
  output logic [6:0]                   seg_out,
  output logic [PAGE_W-1:0]            page_out
);

  localparam int TOTAL  = NUM_PAGES * DIGITS_PER_PAGE;
  localparam int BCD_W  = 4 * TOTAL;
  localparam int IDX_W  = (DIGITS_PER_PAGE > 1) ? $clog2(DIGITS_PER_PAGE) : 1;
  localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int ITER_W = $clog2(RESULT_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t              state;
  logic [RESULT_W-1:0] bin_sh;
  logic [BCD_W-1:0]    bcd_sh;
  logic [ITER_W-1:0]   iter;
  logic                sign_work;
  logic                busy_q;
  logic [BCD_W-1:0]    disp_bcd;
  logic                disp_sign;
  logic [PAGE_W-1:0]   page;
  logic [PAGE_W-1:0]   page_nxt;
  logic                adv_q;
  logic                sel_q;
  logic [CNT_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [6:0]          seg_nxt;

  logic                neg_in;
  logic [RESULT_W-1:0] mag_in;
  logic                commit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift the next binary bit in.
  function automatic logic [BCD_W-1:0] dabble_shift(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] c;
    c = b;
    for (int i = 0; i < TOTAL; i++)
      if (c[4*i +: 4] >= 4'd5) c[4*i +: 4] = c[4*i +: 4] + 4'd3;
    dabble_shift = {c[BCD_W-2:0], in_bit};
  endfunction

  // Negation in RESULT_W bits is exact for the most negative value as an unsigned magnitude.
  assign neg_in = (SIGNED != 0) && res.result_in[RESULT_W-1];
  assign mag_in = neg_in ? (~res.result_in + RESULT_W'(1)) : res.result_in;
  assign commit = (state == S_COMMIT) && !res.result_valid;
  assign res.busy = busy_q;
  assign page_out = page;

  // Converter FSM; a new valid pulse in any state restarts capture so the latest value wins.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bin_sh    <= '0;
      bcd_sh    <= '0;
      iter      <= '0;
      sign_work <= 1'b0;
      busy_q    <= 1'b0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
    end else if (res.result_valid) begin
      bin_sh    <= mag_in;
      bcd_sh    <= '0;
      iter      <= '0;
      sign_work <= neg_in;
      busy_q    <= 1'b1;
      state     <= S_SHIFT;
    end else begin
      case (state)
        S_SHIFT: begin
          bcd_sh <= dabble_shift(bcd_sh, bin_sh[RESULT_W-1]);
          bin_sh <= bin_sh << 1;
          iter   <= iter + ITER_W'(1);
          if (iter == ITER_W'(RESULT_W - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp_bcd  <= bcd_sh;
          disp_sign <= sign_work;
          busy_q    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    page_nxt = page;
    if (!select || commit || !sel_q) begin
      page_nxt = '0;
    end else if (advance && !adv_q) begin
      page_nxt = (page == PAGE_W'(NUM_PAGES - 1)) ? '0 : page + PAGE_W'(1);
    end
  end

  // Segments are built from next-cycle page/digits so a commit or page step shows immediately.
  always_comb begin
    logic [BCD_W-1:0] view_bcd;
    logic             view_sign;
    logic [3:0]       digit;
    logic [3:0]       in_digit;
    int               msd;
    int               k;
    view_bcd  = commit ? bcd_sh : disp_bcd;
    view_sign = commit ? sign_work : disp_sign;
    msd       = 0;
    for (int i = 0; i < TOTAL; i++)
      if (view_bcd[4*i +: 4] != 4'd0) msd = i;
    k     = int'(page_nxt) * DIGITS_PER_PAGE + int'(scan_idx);
    digit = 4'd0;
    for (int i = 0; i < TOTAL; i++)
      if (i == k) digit = view_bcd[4*i +: 4];
    in_digit = 4'd0;
    for (int i = 0; i < DIGITS_PER_PAGE; i++)
      if (i == int'(scan_idx)) in_digit = data_in[4*i +: 4];
    if (!select)                           seg_nxt = glyph(in_digit);
    else if (k <= msd)                     seg_nxt = glyph(digit);
    else if (view_sign && (k == msd + 1))  seg_nxt = SEG_MINUS;
    else                                   seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page     <= '0;
      adv_q    <= 1'b0;
      sel_q    <= 1'b0;
      scan_cnt <= '0;
      scan_idx <= '0;
      an_out   <= '1;
      seg_out  <= SEG_BLANK;
    end else begin
      page    <= page_nxt;
      adv_q   <= advance;
      sel_q   <= select;
      an_out  <= ~(DIGITS_PER_PAGE'(1) << scan_idx);
      seg_out <= seg_nxt;
      if (scan_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(DIGITS_PER_PAGE - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_pager.sv
// Self-checking bench for display_pager: a per-cycle decimal model plus directed
// page captures with hand-computed glyphs.
module tb_display_pager;
  localparam int RW  = 32;
  localparam int DPP = 4;
  localparam int NP  = 3;
  localparam int R   = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, BL = 7'b1111111, MI = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset, select, advance;
  logic [15:0] data_in;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic [1:0]  page_out;

  display_pager_if #(.RESULT_W(RW)) res_if ();

  display_pager #(
    .RESULT_W(RW), .SIGNED(1), .DIGITS_PER_PAGE(DPP), .NUM_PAGES(NP), .REFRESH_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .select(select), .advance(advance), .data_in(data_in),
    .res(res_if), .an_out(an_out), .seg_out(seg_out), .page_out(page_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [10] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};
    glyph = (d < 4'd10) ? tbl[d] : BL;
  endfunction

  function automatic logic [3:0] dec_digit(input longint unsigned v, input int k);
    for (int i = 0; i < k; i++) v = v / 10;
    dec_digit = 4'(v % 10);
  endfunction

  function automatic int msd_of(input longint unsigned v);
    int n = 0;
    while (v >= 10) begin v = v / 10; n++; end
    msd_of = n;
  endfunction

  // Model: committed value in plain decimal, a countdown to the commit, page and scan time.
  longint unsigned m_mag, p_mag;
  bit              m_neg, p_neg, m_busy, adv_prev, sel_prev, commit_now;
  int              m_cnt, m_page, scan_t, lit, k, msd;
  logic [3:0]      e_an;
  logic [6:0]      e_seg;

  always @(posedge clk) begin
    if (reset) begin
      m_mag = 0; m_neg = 0; m_cnt = 0; m_busy = 0; m_page = 0; scan_t = 0;
      adv_prev = 0; sel_prev = 0; e_an = 4'b1111; e_seg = BL;
    end else begin
      commit_now = 0;
      if (res_if.result_valid) begin
        p_neg  = res_if.result_in[RW-1];
        p_mag  = p_neg ? (64'h1_0000_0000 - {32'd0, res_if.result_in}) : {32'd0, res_if.result_in};
        m_cnt  = RW + 1;
        m_busy = 1;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_mag = p_mag; m_neg = p_neg; m_busy = 0; commit_now = 1;
        end
      end
      if (!select || commit_now || !sel_prev) m_page = 0;
      else if (advance && !adv_prev) m_page = (m_page + 1) % NP;
      adv_prev = advance;
      sel_prev = select;
      lit = (scan_t / R) % DPP;
      scan_t++;
      e_an = ~(4'b0001 << lit);
      if (!select) begin
        e_seg = glyph(data_in[4*lit +: 4]);
      end else begin
        k   = m_page * DPP + lit;
        msd = msd_of(m_mag);
        if (k <= msd)                  e_seg = glyph(dec_digit(m_mag, k));
        else if (m_neg && k == msd + 1) e_seg = MI;
        else                           e_seg = BL;
      end
    end
    #1;
    check("cyc_an_out", 32'(an_out), 32'(e_an));
    check("cyc_seg_out", 32'(seg_out), 32'(e_seg));
    check("cyc_busy", 32'(res_if.busy), 32'(m_busy));
    check("cyc_page_out", 32'(page_out), 32'(m_page));
  end

  logic [6:0] cap [DPP];

  task automatic capture_page();
    int n = 0;
    for (int i = 0; i < DPP; i++) cap[i] = 'x;
    while (an_out !== 4'b1110 && n < 50) begin @(negedge clk); n++; end
    check("scan_sync", 32'(an_out), 32'(4'b1110));
    for (int c = 0; c < DPP * R; c++) begin
      for (int i = 0; i < DPP; i++)
        if (an_out == ~(4'b0001 << i)) cap[i] = seg_out;
      @(negedge clk);
    end
  endtask

  // Arguments are listed left to right as on the panel (local digit 3 first).
  task automatic expect_page(input string nm, input logic [6:0] d3, d2, d1, d0);
    capture_page();
    check({nm, "_d0"}, 32'(cap[0]), 32'(d0));
    check({nm, "_d1"}, 32'(cap[1]), 32'(d1));
    check({nm, "_d2"}, 32'(cap[2]), 32'(d2));
    check({nm, "_d3"}, 32'(cap[3]), 32'(d3));
  endtask

  task automatic pulse(input logic [31:0] v, output int busy_cycles);
    res_if.result_in    = v;
    res_if.result_valid = 1'b1;
    @(negedge clk);
    res_if.result_valid = 1'b0;
    busy_cycles = 0;
    while (res_if.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic adv();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    @(negedge clk);
  endtask

  int bc;

  initial begin
    reset = 1'b1; select = 1'b1; advance = 1'b0; data_in = 16'h4321;
    res_if.result_in = '0; res_if.result_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an_out", 32'(an_out), 32'(4'b1111));
    check("rst_seg_out", 32'(seg_out), 32'(BL));
    check("rst_busy", 32'(res_if.busy), 32'd0);
    check("rst_page_out", 32'(page_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_anode", 32'(an_out), 32'(4'b1110));
    expect_page("idle", BL, BL, BL, G0);

    pulse(32'd1234567890, bc);
    check("busy_len_1234567890", bc, 33);
    check("commit_page0", 32'(page_out), 32'd0);
    expect_page("p0", G7, G8, G9, G0);
    adv(); check("adv_page1", 32'(page_out), 32'd1);
    expect_page("p1", G3, G4, G5, G6);
    adv(); check("adv_page2", 32'(page_out), 32'd2);
    expect_page("p2", BL, BL, G1, G2);
    adv(); check("adv_wrap0", 32'(page_out), 32'd0);

    advance = 1'b1;
    repeat (50) @(negedge clk);
    advance = 1'b0;
    @(negedge clk);
    check("held_one_step", 32'(page_out), 32'd1);

    select = 1'b0;
    @(negedge clk);
    adv(); adv(); adv();
    check("input_mode_page", 32'(page_out), 32'd0);
    expect_page("input", G4, G3, G2, G1);
    select = 1'b1;
    @(negedge clk);
    check("select_rise_page", 32'(page_out), 32'd0);

    pulse(32'hFFFF_FFFF, bc);
    check("busy_len_minus1", bc, 33);
    expect_page("minus1", BL, BL, MI, G1);

    pulse(32'h8000_0000, bc);
    adv(); adv();
    check("minint_page2", 32'(page_out), 32'd2);
    expect_page("minint_p2", BL, MI, G2, G1);

    res_if.result_in = 32'd55; res_if.result_valid = 1'b1;
    @(negedge clk);
    res_if.result_valid = 1'b0;
    repeat (9) @(negedge clk);
    pulse(32'd908, bc);
    check("busy_len_restart", bc, 33);
    expect_page("restart", BL, G9, G0, G8);

    res_if.result_in = 32'd777; res_if.result_valid = 1'b1;
    @(negedge clk);
    res_if.result_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(res_if.busy), 32'd0);
    check("midrst_an_out", 32'(an_out), 32'(4'b1111));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_commit_busy", 32'(res_if.busy), 32'd0);
    expect_page("after_reset", BL, BL, BL, G0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
